// File: rtl/cobs_pkg.sv
// Shared definitions for the COBS-over-UART transmit path.
package cobs_pkg;

  localparam logic [7:0] COBS_DELIM = 8'h00;

  typedef enum logic [1:0] {
    FILL,
    FINAL,
    SEND,
    DRAIN
  } tx_state_t;

  // Clocks per UART bit, rounded down.
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/cobs_uart_tx_uart.sv
// UART 8N1 serialiser: start bit 0, eight data bits LSB first, stop bit 1,
// each bit held for exactly DIV clocks. tx idles high.
module uart_tx_8n1 #(
  parameter int unsigned DIV = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic          active_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    bit_q;
  logic [9:0]    shreg_q;
  logic          tx_q;
  logic          stop_end;

  assign stop_end = active_q && (cnt_q == CNT_LAST) && (bit_q == 4'd9);
  // Ready also on the last stop-bit cycle so the next start bit follows with no gap.
  assign ready = !active_q || stop_end;
  assign tx    = tx_q;

  // Bit timing and shifting; a load overrides the end of the current stop bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '1;
      tx_q     <= 1'b1;
    end else if (valid && ready) begin
      active_q <= 1'b1;
      cnt_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= {1'b1, data, 1'b0};
      tx_q     <= 1'b0;
    end else if (active_q) begin
      if (cnt_q == CNT_LAST) begin
        cnt_q <= '0;
        if (bit_q == 4'd9) begin
          active_q <= 1'b0;
          tx_q     <= 1'b1;
        end else begin
          bit_q   <= bit_q + 4'd1;
          shreg_q <= {1'b1, shreg_q[9:1]};
          tx_q    <= shreg_q[1];
        end
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/cobs_uart_tx.sv
// COBS packet encoder and UART transmitter. Buffers one packet, encoding it
// in place while filling, then sends the frame plus a 0x00 delimiter.
module cobs_uart_tx
  import cobs_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115_200,
  parameter int unsigned MAX_LEN  = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic       err
);

  localparam int unsigned DIV = baud_div(CLK_FREQ, BAUD);
  localparam int unsigned AW  = $clog2(MAX_LEN + 1);
  localparam logic [7:0] LAST_POS = 8'(MAX_LEN);

  tx_state_t  state_q, state_d;
  logic [7:0] wr_pos_q, wr_pos_d;
  logic [7:0] code_pos_q, code_pos_d;
  logic [7:0] len_q, len_d;
  logic [7:0] rd_pos_q, rd_pos_d;
  logic       pv_q, pv_d;
  logic       busy_q, busy_d;
  logic       err_q, err_d;

  logic [7:0] mem_q [MAX_LEN+1];
  logic [7:0] rd_data_q;

  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;
  logic          ser_valid;
  logic [7:0]    ser_data;
  logic          ser_ready;
  logic          accept;
  logic          ser_accept;
  logic          ovf;
  logic          at_end;

  assign accept     = in_valid && in_ready;
  assign ser_accept = ser_valid && ser_ready;
  assign ovf        = (wr_pos_q == LAST_POS);
  assign at_end     = (rd_pos_q == len_q);
  assign busy       = busy_q;
  assign err        = err_q;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= FILL;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL:    if (accept && (in_last || ovf)) state_d = FINAL;
      FINAL:   state_d = SEND;
      SEND:    if (ser_accept && at_end) state_d = DRAIN;
      DRAIN:   if (ser_ready) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // FSM outputs: input handshake, buffer write port, serialiser feed.
  always_comb begin
    in_ready  = 1'b0;
    we        = 1'b0;
    waddr     = wr_pos_q[AW-1:0];
    wdata     = in_data;
    ser_valid = 1'b0;
    ser_data  = COBS_DELIM;
    unique case (state_q)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          we = 1'b1;
          if (in_data == COBS_DELIM) begin
            waddr = code_pos_q[AW-1:0];
            wdata = wr_pos_q - code_pos_q;
          end
        end
      end
      FINAL: begin
        we    = 1'b1;
        waddr = code_pos_q[AW-1:0];
        wdata = wr_pos_q - code_pos_q;
      end
      SEND: begin
        ser_valid = pv_q;
        ser_data  = at_end ? COBS_DELIM : rd_data_q;
      end
      DRAIN:   ;
      default: ;
    endcase
  end

  // Datapath next-state: positions, length, read-prime flag, busy and err.
  always_comb begin
    wr_pos_d   = wr_pos_q;
    code_pos_d = code_pos_q;
    len_d      = len_q;
    rd_pos_d   = rd_pos_q;
    pv_d       = pv_q;
    busy_d     = busy_q;
    err_d      = accept && ovf;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          busy_d   = 1'b1;
          wr_pos_d = wr_pos_q + 8'd1;
          if (in_data == COBS_DELIM) code_pos_d = wr_pos_q;
        end
      end
      FINAL: begin
        len_d    = wr_pos_q;
        rd_pos_d = '0;
        pv_d     = 1'b0;
      end
      SEND: begin
        // pv marks rd_data_q as holding buf[rd_pos]; it drops for one cycle after each advance.
        if (ser_accept) begin
          rd_pos_d = rd_pos_q + 8'd1;
          pv_d     = 1'b0;
        end else begin
          pv_d = 1'b1;
        end
      end
      DRAIN: begin
        if (ser_ready) begin
          wr_pos_d   = 8'd1;
          code_pos_d = '0;
          busy_d     = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_pos_q   <= 8'd1;
      code_pos_q <= '0;
      len_q      <= '0;
      rd_pos_q   <= '0;
      pv_q       <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_pos_q   <= wr_pos_d;
      code_pos_q <= code_pos_d;
      len_q      <= len_d;
      rd_pos_q   <= rd_pos_d;
      pv_q       <= pv_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  // Packet buffer: single write port, registered read.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rd_data_q <= mem_q[rd_pos_q[AW-1:0]];
  end

  uart_tx_8n1 #(
    .DIV(DIV)
  ) u_ser (
    .clk  (clk),
    .reset(reset),
    .data (ser_data),
    .valid(ser_valid),
    .ready(ser_ready),
    .tx   (tx)
  );

endmodule

// File: tb/tb_cobs_uart_tx.sv
// Bench for cobs_uart_tx: two instances (MAX_LEN 64 and 4), UART monitors,
// and a COBS reference model that predicts the wire bytes and err pulses.
module tb_cobs_uart_tx;

  localparam int unsigned CLK_FREQ = 50_000_000;
  localparam int unsigned BAUD     = 5_000_000;
  localparam int unsigned DIV      = 10;
  localparam int unsigned MAX0     = 64;
  localparam int unsigned MAX1     = 4;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic [7:0] d0 = '0, d1 = '0;
  logic v0 = 1'b0, v1 = 1'b0, l0 = 1'b0, l1 = 1'b0;
  logic r0, r1, tx0, tx1, b0, b1, e0, e1;

  cobs_uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .MAX_LEN(MAX0)) dut0 (
    .clk(clk), .reset(rst_n), .in_data(d0), .in_valid(v0), .in_last(l0),
    .in_ready(r0), .tx(tx0), .busy(b0), .err(e0));

  cobs_uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .MAX_LEN(MAX1)) dut1 (
    .clk(clk), .reset(rst_n), .in_data(d1), .in_valid(v1), .in_last(l1),
    .in_ready(r1), .tx(tx1), .busy(b1), .err(e1));

  int checks = 0;
  int failures = 0;

  bq_t got0, got1, exp0, exp1, cur0, cur1;
  int unsigned experr0 = 0, experr1 = 0;
  int unsigned errs0 = 0, errs1 = 0;
  int unsigned epoch = 0;

  always @(negedge clk) begin
    if (!rst_n) epoch++;
    if (rst_n && e0) errs0++;
    if (rst_n && e1) errs1++;
  end

  function automatic logic txof(input int d);
    return (d == 0) ? tx0 : tx1;
  endfunction
  function automatic logic rdyof(input int d);
    return (d == 0) ? r0 : r1;
  endfunction
  function automatic logic busyof(input int d);
    return (d == 0) ? b0 : b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_s(input string tag, input string obs, input string exp);
    checks++;
    assert (obs == exp) else begin
      failures++;
      $error("FAIL %s observed=[%s] expected=[%s]", tag, obs, exp);
    end
  endtask

  // UART receiver: samples mid-bit on falling clock edges; drops a byte cut by reset.
  task automatic uart_rx(input int d);
    logic [7:0] b;
    int unsigned ep;
    forever begin
      @(negedge clk);
      if (rst_n && txof(d) == 1'b0) begin
        ep = epoch;
        repeat (DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = txof(d);
        end
        repeat (DIV) @(negedge clk);
        if (ep == epoch && rst_n && txof(d) == 1'b1) begin
          if (d == 0) got0.push_back(b);
          else        got1.push_back(b);
        end
      end
    end
  endtask

  initial uart_rx(0);
  initial uart_rx(1);

  // Reference: collect payload; on last or when full, emit the COBS groups and a delimiter.
  task automatic model_byte(input int d, input logic [7:0] b, input bit last);
    bq_t c, grp, e;
    int unsigned mx;
    mx = (d == 0) ? MAX0 : MAX1;
    c  = (d == 0) ? cur0 : cur1;
    e  = (d == 0) ? exp0 : exp1;
    c.push_back(b);
    if (last || c.size() == mx) begin
      if (c.size() == mx) begin
        if (d == 0) experr0++;
        else        experr1++;
      end
      grp = {};
      foreach (c[i]) begin
        if (c[i] == 8'h00) begin
          e.push_back(8'(grp.size() + 1));
          foreach (grp[j]) e.push_back(grp[j]);
          grp = {};
        end else begin
          grp.push_back(c[i]);
        end
      end
      e.push_back(8'(grp.size() + 1));
      foreach (grp[j]) e.push_back(grp[j]);
      e.push_back(8'h00);
      c = {};
    end
    if (d == 0) begin cur0 = c; exp0 = e; end
    else        begin cur1 = c; exp1 = e; end
  endtask

  task automatic send_byte(input int d, input logic [7:0] b, input bit last);
    int unsigned n;
    n = 0;
    @(negedge clk);
    if (d == 0) begin d0 = b; v0 = 1'b1; l0 = last; end
    else        begin d1 = b; v1 = 1'b1; l1 = last; end
    while (rdyof(d) !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      failures++;
      $display("FAIL in_ready_timeout dut=%0d observed=0 expected=1", d);
    end
    @(posedge clk);
    model_byte(d, b, last);
    #1;
    if (d == 0) begin v0 = 1'b0; l0 = 1'b0; end
    else        begin v1 = 1'b0; l1 = 1'b0; end
  endtask

  task automatic send_pkt(input int d, input bq_t p, input bit close);
    foreach (p[i]) send_byte(d, p[i], close && (i == p.size() - 1));
  endtask

  // Wait for frame end; in_ready must stay low while busy after the packet closed.
  task automatic wait_idle(input int d, input string tag);
    int unsigned n, viol;
    n = 0;
    viol = 0;
    while (!(busyof(d) == 1'b0 && rdyof(d) == 1'b1) && n < 20000) begin
      @(negedge clk);
      if (busyof(d) && rdyof(d)) viol++;
      n++;
    end
    chk({tag, "_idle_reached"}, 32'(n < 20000), 32'd1);
    chk({tag, "_ready_while_busy"}, viol, 32'd0);
  endtask

  function automatic string hexs(input bq_t q);
    string s;
    s = "";
    foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
    return s;
  endfunction

  task automatic check_frames(input int d, input string tag);
    if (d == 0) begin
      chk_s(tag, hexs(got0), hexs(exp0));
      got0 = {};
      exp0 = {};
    end else begin
      chk_s(tag, hexs(got1), hexs(exp1));
      got1 = {};
      exp1 = {};
    end
  endtask

  initial begin
    bq_t p;
    bq_t tb;
    int unsigned n, mism, len;
    logic busy_at_last;
    logic [7:0] byt;
    int unsigned k, bn;
    logic expbit;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx0", tx0, 1);
    chk("rst_busy0", b0, 0);
    chk("rst_err0", e0, 0);
    chk("rst_ready0", r0, 1);
    chk("rst_tx1", tx1, 1);
    chk("rst_ready1", r1, 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: {11,22,00,33}
    p = '{8'h11, 8'h22, 8'h00, 8'h33};
    send_pkt(0, p, 1'b1);
    wait_idle(0, "t1");
    check_frames(0, "t1_frame");
    chk("t1_err", errs0, experr0);

    // 2: {00}
    p = '{8'h00};
    send_pkt(0, p, 1'b1);
    wait_idle(0, "t2");
    check_frames(0, "t2_frame");

    // 3: {11,22,33,44}
    p = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_pkt(0, p, 1'b1);
    chk("t3_busy_after_last", b0, 1);
    wait_idle(0, "t3");
    chk("t3_tx_idle", tx0, 1);
    check_frames(0, "t3_frame");

    // 4: {55} with cycle-exact line check against 02 55 00
    p = '{8'h55};
    send_pkt(0, p, 1'b1);
    tb = '{8'h02, 8'h55, 8'h00};
    n = 0;
    while (tx0 !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("t4_start_seen", 32'(n < 1000), 32'd1);
    mism = 0;
    busy_at_last = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (c > 0) @(negedge clk);
      k  = 32'(c) / DIV;
      bn = k % 10;
      byt = tb[k / 10];
      if (bn == 0)      expbit = 1'b0;
      else if (bn == 9) expbit = 1'b1;
      else              expbit = byt[bn - 1];
      if (tx0 !== expbit) mism++;
      if (c == 299) busy_at_last = b0;
    end
    chk("t4_waveform_mismatches", mism, 0);
    chk("t4_busy_last_stop_cycle", busy_at_last, 1);
    @(negedge clk);
    chk("t4_busy_after_frame", b0, 0);
    chk("t4_tx_after_frame", tx0, 1);
    wait_idle(0, "t4");
    check_frames(0, "t4_frame");

    // 5: MAX_LEN=4 overflow, then 05,06 open a new packet closed by 07
    p = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_pkt(1, p, 1'b0);
    chk("t5_err_pulses", errs1, experr1);
    chk("t5_err_one", errs1, 1);
    send_byte(1, 8'h07, 1'b1);
    wait_idle(1, "t5");
    check_frames(1, "t5_frames");

    // 6: reset mid-byte during a {11,22,33,44} frame
    p = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_pkt(0, p, 1'b1);
    n = 0;
    while (tx0 !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    repeat (35) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_tx", tx0, 1);
    chk("t6_busy", b0, 0);
    chk("t6_ready", r0, 1);
    rst_n = 1'b1;
    cur0 = {};
    exp0 = {};
    repeat (120) @(negedge clk);
    got0 = {};
    p = '{8'h00};
    send_pkt(0, p, 1'b1);
    wait_idle(0, "t6");
    check_frames(0, "t6_frame");

    // Random packets, MAX_LEN=64
    for (int t = 0; t < 10; t++) begin
      len = $urandom_range(1, 24);
      p = {};
      for (int i = 0; i < int'(len); i++)
        p.push_back(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
      send_pkt(0, p, 1'b1);
      wait_idle(0, $sformatf("r0_%0d", t));
      check_frames(0, $sformatf("r0_%0d_frame", t));
    end

    // Random packets, MAX_LEN=4 (overflow splits)
    for (int t = 0; t < 10; t++) begin
      len = $urandom_range(1, 9);
      p = {};
      for (int i = 0; i < int'(len); i++)
        p.push_back(($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
      send_pkt(1, p, 1'b1);
      wait_idle(1, $sformatf("r1_%0d", t));
      check_frames(1, $sformatf("r1_%0d_frame", t));
    end

    chk("err0_total", errs0, experr0);
    chk("err1_total", errs1, experr1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
